// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU LSU and a host/DMA port.
// Ports: cpu_* and host_* req/gnt/rvalid handshakes, host_lock burst hold, mem_* command/return.
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_R,
  output logic              mem_W,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_out,
  input  logic [DATA_W-1:0] mem_in
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

  logic          last;
  logic [CW-1:0] lock_cnt;
  logic          lock_win;
  logic          host_pick;
  logic          any_gnt;
  logic          sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // owner pipeline, first stage; second stage is the rvalid register
  logic rd_v;
  logic rd_own;

  always_comb begin
    lock_win  = host_lock && last && (lock_cnt < LMAX);
    host_pick = host_req && (!cpu_req || !last || lock_win);
    host_gnt  = rst && host_pick;
    cpu_gnt   = rst && cpu_req && !host_pick;
    any_gnt   = cpu_gnt || host_gnt;
    sel_we    = host_gnt ? host_we    : cpu_we;
    sel_addr  = host_gnt ? host_addr  : cpu_addr;
    sel_wdata = host_gnt ? host_wdata : cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last        <= 1'b1;
      lock_cnt    <= '0;
      mem_R       <= 1'b0;
      mem_W       <= 1'b0;
      mem_address <= '0;
      mem_out     <= '0;
      rd_v        <= 1'b0;
      rd_own      <= 1'b0;
      cpu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      cpu_rdata   <= '0;
      host_rdata  <= '0;
    end else begin
      if (cpu_gnt) begin
        last <= 1'b0;
      end else if (host_gnt) begin
        last <= 1'b1;
      end

      // only count host grants that actually starve a waiting CPU
      if (cpu_gnt || !host_lock) begin
        lock_cnt <= '0;
      end else if (host_gnt && cpu_req && lock_cnt < LMAX) begin
        lock_cnt <= lock_cnt + CW'(1);
      end

      mem_R <= any_gnt;
      mem_W <= any_gnt && sel_we;
      if (any_gnt) begin
        mem_address <= sel_addr;
        mem_out     <= sel_wdata;
      end

      rd_v   <= any_gnt && !sel_we;
      rd_own <= host_gnt;

      cpu_rvalid  <= rd_v && !rd_own;
      host_rvalid <= rd_v && rd_own;
      if (rd_v && !rd_own) begin
        cpu_rdata <= mem_in;
      end
      if (rd_v && rd_own) begin
        host_rdata <= mem_in;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus scoreboard bench for dmem_arbiter.
// Ports: drives both requesters, models an async-read DATA_MEM on the mem_* side.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LM = 8;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_R, mem_W;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_out;
  logic [DW-1:0] mem_in;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_R(mem_R), .mem_W(mem_W),
    .mem_address(mem_address), .mem_out(mem_out),
    .mem_in(mem_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ref_mem [1024];

  assign mem_in = mem[mem_address];

  always @(posedge clk) begin
    if (mem_R && mem_W) mem[mem_address] <= mem_out;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    bit          own;
    logic [DW-1:0] d;
  } ret_t;

  ret_t dq[$];

  int            cyc = 0;
  logic          m_last;
  int            m_cnt;
  logic          m_R, m_W;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_out;

  always @(negedge clk) begin
    logic e_hg, e_cg, e_cv, e_hv, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    cyc++;
    if (!rst) begin
      chk("rst_gnt", {cpu_gnt, host_gnt}, 0);
      chk("rst_mem", {mem_R, mem_W, mem_address, mem_out}, 0);
      chk("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
      chk("rst_rdata", {cpu_rdata, host_rdata}, 0);
      m_last = 1'b1;
      m_cnt  = 0;
      m_R    = 1'b0;
      m_W    = 1'b0;
      m_addr = '0;
      m_out  = '0;
      dq.delete();
    end else begin
      e_hg = host_req && (!cpu_req || !m_last ||
             (host_lock && m_last && m_cnt < LM));
      e_cg = cpu_req && !e_hg;
      chk("gnt", {cpu_gnt, host_gnt}, {e_cg, e_hg});
      chk("mem_cmd", {mem_R, mem_W}, {m_R, m_W});
      chk("mem_addr", mem_address, m_addr);
      chk("mem_wdata", mem_out, m_out);
      e_cv = 1'b0;
      e_hv = 1'b0;
      if (dq.size() > 0 && dq[0].due == cyc) begin
        if (dq[0].own) e_hv = 1'b1;
        else e_cv = 1'b1;
      end
      chk("rvalid", {cpu_rvalid, host_rvalid}, {e_cv, e_hv});
      if (e_cv) chk("cpu_rdata", cpu_rdata, dq[0].d);
      if (e_hv) chk("host_rdata", host_rdata, dq[0].d);
      if (e_cv || e_hv) void'(dq.pop_front());
      m_R = e_cg || e_hg;
      m_W = 1'b0;
      if (e_cg || e_hg) begin
        we = e_hg ? host_we : cpu_we;
        a  = e_hg ? host_addr : cpu_addr;
        wd = e_hg ? host_wdata : cpu_wdata;
        m_W    = we;
        m_addr = a;
        m_out  = wd;
        if (we) ref_mem[a] = wd;
        else dq.push_back('{due: cyc + 2, own: e_hg, d: ref_mem[a]});
      end
      if (e_cg || !host_lock) m_cnt = 0;
      else if (e_hg && cpu_req && m_cnt < LM) m_cnt++;
      if (e_cg) m_last = 1'b0;
      else if (e_hg) m_last = 1'b1;
    end
  end

  typedef struct {
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          hr, hw;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic          hl;
    logic          ec, eh;
  } vec_t;

  function automatic vec_t mk(
    logic cr, logic cw, int ca, int cd,
    logic hr, logic hw, int ha, int hd,
    logic hl, logic ec, logic eh);
    vec_t v;
    v.cr = cr; v.cw = cw;
    v.ca = AW'(ca); v.cd = DW'(cd);
    v.hr = hr; v.hw = hw;
    v.ha = AW'(ha); v.hd = DW'(hd);
    v.hl = hl; v.ec = ec; v.eh = eh;
    return v;
  endfunction

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    host_lock = 0;
  endtask

  vec_t vt[18];
  int   seq[40];

  initial begin
    int n, hleft, cat;
    bit cpend, got;
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = DW'(i * 37 + 11);
    end
    mem[1] = 16'd15;
    mem[2] = 16'd4;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];

    vt[0]  = mk(1,1,5,'h14, 1,0,5,0,   0, 1,0);
    vt[1]  = mk(0,0,0,0,    1,0,5,0,   0, 0,1);
    vt[2]  = mk(0,0,0,0,    0,0,0,0,   0, 0,0);
    vt[3]  = mk(1,0,2,0,    0,0,0,0,   0, 1,0);
    vt[4]  = mk(0,0,0,0,    1,1,20,'h55, 0, 0,1);
    vt[5]  = mk(1,0,10,0,   1,0,20,0,  0, 1,0);
    vt[6]  = mk(1,0,11,0,   1,0,20,0,  0, 0,1);
    vt[7]  = mk(1,0,11,0,   1,0,21,0,  0, 1,0);
    vt[8]  = mk(1,0,12,0,   1,0,21,0,  0, 0,1);
    vt[9]  = mk(1,0,12,0,   1,0,22,0,  0, 1,0);
    vt[10] = mk(1,0,13,0,   1,0,22,0,  0, 0,1);
    vt[11] = mk(1,0,13,0,   1,0,23,0,  0, 1,0);
    vt[12] = mk(0,0,0,0,    1,0,23,0,  0, 0,1);
    vt[13] = mk(0,0,0,0,    0,0,0,0,   0, 0,0);
    vt[14] = mk(1,0,7,0,    0,0,0,0,   0, 1,0);
    vt[15] = mk(1,0,40,0,   1,0,30,0,  0, 0,1);
    vt[16] = mk(0,0,0,0,    0,0,0,0,   0, 0,0);
    vt[17] = mk(0,0,0,0,    0,0,0,0,   0, 0,0);

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      cpu_req = vt[i].cr; cpu_we = vt[i].cw;
      cpu_addr = vt[i].ca; cpu_wdata = vt[i].cd;
      host_req = vt[i].hr; host_we = vt[i].hw;
      host_addr = vt[i].ha; host_wdata = vt[i].hd;
      host_lock = vt[i].hl;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i),
          {cpu_gnt, host_gnt}, {vt[i].ec, vt[i].eh});
    end

    hleft = 12;
    cpend = 1;
    n = 0;
    cat = -10;
    while ((hleft > 0 || cpend) && n < 40) begin
      @(posedge clk);
      #1;
      host_lock = 1;
      host_req = (hleft > 0);
      host_we = 0;
      host_addr = AW'(100 + 12 - hleft);
      cpu_req = cpend;
      cpu_we = 0;
      cpu_addr = 3;
      @(negedge clk);
      if (n == cat + 1) chk("lock_cnt_clr", 32'(dut.lock_cnt), 0);
      if (host_gnt) begin
        seq[n] = 1;
        hleft--;
      end else if (cpu_gnt) begin
        seq[n] = 0;
        cpend = 0;
        cat = n;
      end else begin
        seq[n] = 2;
      end
      n++;
    end
    chk("lock_len", n, 13);
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("lock_seq%0d", i), seq[i], (i == 8) ? 0 : 1);
    end
    @(posedge clk);
    #1 idle_inputs();
    repeat (4) @(posedge clk);

    #1;
    host_req = 1; host_we = 0; host_addr = 50;
    @(negedge clk);
    chk("rmid_gnt", host_gnt, 1);
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    chk("rmid_hrv", host_rvalid, 0);
    chk("rmid_mem", {mem_R, mem_W}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rmid_hrv2", host_rvalid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 1;
    @(negedge clk);
    chk("post_rst_gnt", cpu_gnt, 1);
    @(posedge clk);
    #1 idle_inputs();
    got = 0;
    for (int k = 0; k < 5 && !got; k++) begin
      @(negedge clk);
      if (cpu_rvalid) begin
        got = 1;
        chk("post_rst_rdata", cpu_rdata, 15);
      end
      @(posedge clk);
      #1;
    end
    chk("post_rst_rvalid_seen", got, 1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
